// File: rtl/stream_demux8_pkg.sv
// Shared constants and slot state type for the 1-to-8 stream demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_OUT   = 8;
  localparam int unsigned SEL_WIDTH = 3;
  // All-ones saturation value; truncated to the counter width where used.
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/stream_demux8_if.sv
// Handshake bundle for stream_demux8: one input stream, eight output lanes.
interface stream_demux8_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  import demux_pkg::*;

  logic                            in_valid;
  logic                            in_ready;
  logic [SEL_WIDTH-1:0]            in_sel;
  logic [DATA_WIDTH-1:0]           in_data;
  logic [NUM_OUT-1:0]              out_valid;
  logic [NUM_OUT-1:0]              out_ready;
  logic [NUM_OUT*DATA_WIDTH-1:0]   out_data;

  // Producer plus the eight consumers.
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The demultiplexer itself.
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_demux8_slot.sv
// One-entry output register slot: EMPTY/FULL state plus a held payload.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data
);

  slot_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // A load wins over a drain so a same-cycle refill keeps the slot FULL.
  always_comb begin
    state_nxt = state;
    if (load)                        state_nxt = FULL;
    else if (state == FULL && ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst)       data <= '0;
    else if (load) data <= din;
  end

  assign full = (state == FULL);

endmodule

// File: rtl/stream_demux8.sv
// 1-to-8 valid/ready stream demultiplexer with a register slot per lane.
// Optional per-lane saturating beat counters under `STREAM_DEMUX8_CNT_EN.
module stream_demux8
  import demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
`ifdef STREAM_DEMUX8_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH  = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  stream_demux8_if.slave             bus
`ifdef STREAM_DEMUX8_CNT_EN
  ,
  input  logic                       cnt_clr,
  output logic [NUM_OUT*CNT_WIDTH-1:0] cnt_flat
`endif
);

  logic [NUM_OUT-1:0]            full;
  logic [NUM_OUT-1:0]            load;
  logic [NUM_OUT*DATA_WIDTH-1:0] data_flat;
  logic                          accept;

  // Only the selected lane gates the input; no bypass to other lanes.
  assign bus.in_ready = ~full[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    load = '0;
    if (accept) load[bus.in_sel] = 1'b1;
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    demux_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .ready (bus.out_ready[i]),
      .din   (bus.in_data),
      .full  (full[i]),
      .data  (data_flat[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.out_valid = full;
  assign bus.out_data  = data_flat;

`ifdef STREAM_DEMUX8_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(CNT_MAX);

  logic [NUM_OUT-1:0] drain;
  assign drain = full & bus.out_ready;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;

    // Clear outranks a same-cycle drain; counts stick at all-ones.
    always_ff @(posedge clk) begin
      if (rst || cnt_clr)              cnt <= '0;
      else if (drain[i] && cnt != CNT_SAT) cnt <= cnt + CNT_WIDTH'(1);
    end

    assign cnt_flat[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`endif

endmodule

// File: tb/tb_stream_demux8.sv
// Directed self-checking bench for stream_demux8 (counter test when STREAM_DEMUX8_CNT_EN).
module tb_stream_demux8;
  import demux_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stream_demux8_if #(.DATA_WIDTH(DW)) bus ();

`ifdef STREAM_DEMUX8_CNT_EN
  logic                 cnt_clr = 1'b0;
  logic [NUM_OUT*CW-1:0] cnt_flat;

  stream_demux8 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .cnt_clr  (cnt_clr),
    .cnt_flat (cnt_flat)
  );
`else
  stream_demux8 #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
`endif

  // Producer must keep a stalled beat stable while it stays valid.
  assert property (@(posedge clk) disable iff (rst)
    (bus.in_valid && !bus.in_ready) |=>
      (!bus.in_valid || ($stable(bus.in_sel) && $stable(bus.in_data))));

  function automatic logic [DW-1:0] lane(input int i);
    return bus.out_data[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_sel    = 3'd0;
    bus.in_data   = '0;
    bus.out_ready = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 8'h00) begin
      errors++; $display("FAIL reset_valid got %h exp 00", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("FAIL reset_data got %h exp 0", bus.out_data);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", bus.in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    bus.out_ready = 8'hFF;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'd5;
    bus.in_data   = 32'hDEADBEEF;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 8'h20) begin
      errors++; $display("FAIL single_valid got %h exp 20", bus.out_valid);
    end
    checks++;
    if (lane(5) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_data got %h exp deadbeef", lane(5));
    end
    tick();
    checks++;
    if (bus.out_valid !== 8'h00) begin
      errors++; $display("FAIL single_drain got %h exp 00", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'd2;
    bus.in_data   = 32'h2222_0002;
    tick();
    checks++;
    if (bus.out_valid !== 8'h04) begin
      errors++; $display("FAIL bp_fill got %h exp 04", bus.out_valid);
    end
    bus.in_data = 32'hBAD0_0002;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall got %b exp 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 8'h04 || lane(2) !== 32'h2222_0002) begin
      errors++; $display("FAIL bp_hold got %h/%h exp 04/22220002", bus.out_valid, lane(2));
    end
    bus.in_valid = 1'b0;
    bus.in_sel   = 3'd3;
    bus.in_data  = 32'h3333_0003;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_other got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 8'h0C || lane(3) !== 32'h3333_0003 || lane(2) !== 32'h2222_0002) begin
      errors++; $display("FAIL bp_two got %h/%h/%h exp 0c/33330003/22220002",
                         bus.out_valid, lane(3), lane(2));
    end
    bus.out_ready = 8'h0C;
    tick();
    checks++;
    if (bus.out_valid !== 8'h00) begin
      errors++; $display("FAIL bp_drain got %h exp 00", bus.out_valid);
    end
    bus.out_ready = 8'h00;
  endtask

  task automatic test_streaming();
    bus.out_ready = 8'h80;
    bus.in_sel    = 3'd7;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h7000_0000 + 32'(k);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready beat %0d got %b exp 1", k, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 8'h80 || lane(7) !== 32'h7000_0000 + 32'(k)) begin
        errors++; $display("FAIL stream_data beat %0d got %h/%h exp 80/%h",
                           k, bus.out_valid, lane(7), 32'h7000_0000 + 32'(k));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 8'h00) begin
      errors++; $display("FAIL stream_end got %h exp 00", bus.out_valid);
    end
    bus.out_ready = 8'h00;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'd0;
    bus.in_data   = 32'h0000_00A0;
    tick();
    bus.in_sel  = 3'd4;
    bus.in_data = 32'h0000_00A4;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 8'h11) begin
      errors++; $display("FAIL rmid_fill got %h exp 11", bus.out_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 8'h00 || lane(0) !== 32'h0 || lane(4) !== 32'h0) begin
      errors++; $display("FAIL rmid_clear got %h/%h/%h exp 00/0/0",
                         bus.out_valid, lane(0), lane(4));
    end
    rst = 1'b0;
    bus.out_ready = 8'hFF;
    tick();
    checks++;
    if (bus.out_valid !== 8'h00) begin
      errors++; $display("FAIL rmid_after got %h exp 00", bus.out_valid);
    end
    bus.out_ready = 8'h00;
  endtask

`ifdef STREAM_DEMUX8_CNT_EN
  task automatic test_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (cnt_flat !== '0) begin
      errors++; $display("FAIL cnt_clear got %h exp 0", cnt_flat);
    end
    bus.out_ready = 8'h02;
    bus.in_sel    = 3'd1;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h1000_0000 + 32'(k);
      tick();
      if (k == 2) begin
        checks++;
        if (cnt_flat[1*CW +: CW] !== 2'd2) begin
          errors++; $display("FAIL cnt_mid got %0d exp 2", cnt_flat[1*CW +: CW]);
        end
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (cnt_flat[1*CW +: CW] !== 2'd3) begin
      errors++; $display("FAIL cnt_sat got %0d exp 3", cnt_flat[1*CW +: CW]);
    end
    checks++;
    if (cnt_flat[0*CW +: CW] !== 2'd0 || cnt_flat[7*CW +: CW] !== 2'd0) begin
      errors++; $display("FAIL cnt_other got %h exp lanes 0,7 zero", cnt_flat);
    end
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1111_1111;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h02;
    cnt_clr       = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (cnt_flat[1*CW +: CW] !== 2'd0 || bus.out_valid !== 8'h00) begin
      errors++; $display("FAIL cnt_clr_drain got %0d/%h exp 0/00",
                         cnt_flat[1*CW +: CW], bus.out_valid);
    end
    tick();
    checks++;
    if (cnt_flat[1*CW +: CW] !== 2'd0) begin
      errors++; $display("FAIL cnt_idle got %0d exp 0", cnt_flat[1*CW +: CW]);
    end
    bus.out_ready = 8'h00;
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = 3'd0;
    bus.in_data   = '0;
    bus.out_ready = 8'h00;
    test_reset();
    test_single_beat();
    test_backpressure();
    test_streaming();
    test_reset_mid();
`ifdef STREAM_DEMUX8_CNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
